// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point add/subtract (default bfloat16, 1/8/7) with
// round-to-nearest-even, special-value handling, exception flags and valid/ready backpressure.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_res,
    output logic [3:0]               out_flags
);

    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned F   = MAN_W + 4;          // {hidden, man, G, R, S}
    localparam int unsigned EW  = EXP_W + 2;
    localparam int unsigned LZW = $clog2(F + 1);
    localparam int unsigned RW  = MAN_W + 2;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- stage 1: classify, swap, align ----------------
    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;
    logic [EXP_W-1:0] ea, eb, big_e, sml_e, diff;
    logic [MAN_W-1:0] ma, mb, big_m, sml_m;
    logic [F-1:0]     sml_full, sml_al;
    logic [2*F-1:0]   sml_ext;
    logic             spec1_d;
    logic [W-1:0]     spec1_res_d;
    logic [3:0]       spec1_flags_d;

    always_comb begin
        sa      = in_a[W-1];
        sb      = in_b[W-1] ^ in_sub;
        ea      = in_a[W-2 -: EXP_W];
        eb      = in_b[W-2 -: EXP_W];
        ma      = in_a[MAN_W-1:0];
        mb      = in_b[MAN_W-1:0];
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_nan   = (&ea) && (|ma);
        b_nan   = (&eb) && (|mb);
        a_inf   = (&ea) && !(|ma);
        b_inf   = (&eb) && !(|mb);
        a_ge_b  = {ea, ma} >= {eb, mb};
        big_e   = a_ge_b ? ea : eb;
        big_m   = a_ge_b ? ma : mb;
        sml_e   = a_ge_b ? eb : ea;
        sml_m   = a_ge_b ? mb : ma;
        diff    = big_e - sml_e;
        sml_full = {1'b1, sml_m, 3'b000};
        sml_ext  = {sml_full, {F{1'b0}}} >> diff;
        // Everything shifted below S collapses into the sticky bit.
        if (32'(diff) >= F) begin
            sml_al = F'(1);
        end else begin
            sml_al = {sml_ext[2*F-1:F+1], sml_ext[F] | (|sml_ext[F-1:0])};
        end

        spec1_d       = 1'b1;
        spec1_res_d   = '0;
        spec1_flags_d = '0;
        if (a_nan || b_nan) begin
            spec1_res_d = QNAN;
        end else if (a_inf && b_inf) begin
            if (sa != sb) begin
                spec1_res_d   = QNAN;
                spec1_flags_d = 4'b1000;
            end else begin
                spec1_res_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (a_inf) begin
            spec1_res_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec1_res_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec1_res_d = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            spec1_res_d = {sb, in_b[W-2:0]};
        end else if (b_zero) begin
            spec1_res_d = in_a;
        end else begin
            spec1_d = 1'b0;
        end
    end

    logic          s1_valid, s1_spec, s1_sign, s1_sub;
    logic [W-1:0]  s1_spec_res;
    logic [3:0]    s1_spec_flags;
    logic [EW-1:0] s1_exp;
    logic [F-1:0]  s1_big, s1_sml;

    // ---------------- stage 2: add/subtract and normalise ----------------
    logic [F:0]     sum;
    logic [LZW-1:0] lzc;
    logic           lz_found;
    logic [F-1:0]   norm_d;
    logic [EW-1:0]  exp2_d;
    logic           zero2_d;

    always_comb begin
        sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_sml})
                     : ({1'b0, s1_big} + {1'b0, s1_sml});
        lzc      = LZW'(F);
        lz_found = 1'b0;
        for (int i = int'(F) - 1; i >= 0; i--) begin
            if (!lz_found && sum[i]) begin
                lzc      = LZW'(int'(F) - 1 - i);
                lz_found = 1'b1;
            end
        end
        norm_d  = '0;
        exp2_d  = s1_exp;
        zero2_d = 1'b0;
        if (sum[F]) begin
            norm_d = {sum[F:2], sum[1] | sum[0]};
            exp2_d = s1_exp + EW'(1);
        end else if (!lz_found) begin
            zero2_d = 1'b1;
        end else begin
            norm_d = sum[F-1:0] << lzc;
            exp2_d = s1_exp - EW'(lzc);
        end
    end

    logic          s2_valid, s2_spec, s2_sign, s2_zero;
    logic [W-1:0]  s2_spec_res;
    logic [3:0]    s2_spec_flags;
    logic [EW-1:0] s2_exp;
    logic [F-1:0]  s2_man;

    // ---------------- stage 3: round, range check, pack ----------------
    logic          g3, r3, st3, inc3, inex3;
    logic [RW-1:0] rnd;
    logic [EW-1:0] exp3;
    logic [MAN_W-1:0] man3;
    logic [W-1:0]  res3_d;
    logic [3:0]    flags3_d;

    always_comb begin
        g3    = s2_man[2];
        r3    = s2_man[1];
        st3   = s2_man[0];
        inc3  = g3 && (r3 || st3 || s2_man[3]);
        inex3 = g3 | r3 | st3;
        rnd   = {1'b0, s2_man[F-1:3]} + RW'(inc3);
        exp3  = s2_exp + EW'(rnd[MAN_W+1]);
        man3  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        res3_d   = {s2_sign, exp3[EXP_W-1:0], man3};
        flags3_d = {3'b000, inex3};
        if (s2_spec) begin
            res3_d   = s2_spec_res;
            flags3_d = s2_spec_flags;
        end else if (s2_zero) begin
            res3_d   = '0;
            flags3_d = '0;
        end else if (exp3[EW-1] || (exp3 == '0)) begin
            res3_d   = {s2_sign, {(W-1){1'b0}}};
            flags3_d = 4'b0011;
        end else if (exp3 >= EXP_MAX) begin
            res3_d   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags3_d = 4'b0101;
        end
    end

    // Pipeline registers; every stage holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_spec       <= 1'b0;
            s1_sign       <= 1'b0;
            s1_sub        <= 1'b0;
            s1_spec_res   <= '0;
            s1_spec_flags <= '0;
            s1_exp        <= '0;
            s1_big        <= '0;
            s1_sml        <= '0;
            s2_valid      <= 1'b0;
            s2_spec       <= 1'b0;
            s2_sign       <= 1'b0;
            s2_zero       <= 1'b0;
            s2_spec_res   <= '0;
            s2_spec_flags <= '0;
            s2_exp        <= '0;
            s2_man        <= '0;
            out_valid     <= 1'b0;
            out_res       <= '0;
            out_flags     <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_spec       <= spec1_d;
                s1_spec_res   <= spec1_res_d;
                s1_spec_flags <= spec1_flags_d;
                s1_sign       <= a_ge_b ? sa : sb;
                s1_sub        <= sa ^ sb;
                s1_exp        <= EW'(big_e);
                s1_big        <= {1'b1, big_m, 3'b000};
                s1_sml        <= sml_al;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_spec       <= s1_spec;
                s2_spec_res   <= s1_spec_res;
                s2_spec_flags <= s1_spec_flags;
                s2_sign       <= s1_sign;
                s2_zero       <= zero2_d;
                s2_exp        <= exp2_d;
                s2_man        <= norm_d;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_res   <= res3_d;
                out_flags <= flags3_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed spec vectors plus random traffic
// checked against a real-arithmetic reference model, with backpressure and reset.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_res;
    logic [3:0]  out_flags;

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flags(out_flags)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   tcyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic real to_real(input logic [15:0] x);
        logic [63:0] bits;
        if (x[14:7] == 8'd0) return 0.0;
        bits = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
        return $bitstoreal(bits);
    endfunction

    // Reference: special-value rules, then exact-ish real sum rounded to 8 significant bits.
    function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up, inex, rs;
        real va, vb, s, err, err_mag;
        logic [63:0] bits;
        logic [44:0] rest, half;
        logic [6:0]  keep;
        logic [8:0]  m;
        int e;
        sa = a[15];
        sb = b[15] ^ sub;
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 0);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 0);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 0);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 0);
        a_zero = (a[14:7] == 8'h00);
        b_zero = (b[14:7] == 8'h00);
        if (a_nan || b_nan) return {16'h7FC0, 4'b0000};
        if (a_inf && b_inf) return (sa != sb) ? {16'h7FC0, 4'b1000} : {sa, 15'h7F80, 4'b0000};
        if (a_inf) return {sa, 15'h7F80, 4'b0000};
        if (b_inf) return {sb, 15'h7F80, 4'b0000};
        if (a_zero && b_zero) return {sa & sb, 15'h0000, 4'b0000};
        if (a_zero) return {sb, b[14:0], 4'b0000};
        if (b_zero) return {a, 4'b0000};
        va = to_real({sa, a[14:0]});
        vb = to_real({sb, b[14:0]});
        s  = va + vb;
        if ((va < 0.0 ? -va : va) >= (vb < 0.0 ? -vb : vb)) err = vb - (s - va);
        else err = va - (s - vb);
        if (s == 0.0) return {16'h0000, 4'b0000};
        err_mag = (s < 0.0) ? -err : err;
        bits = $realtobits(s);
        rs   = bits[63];
        e    = int'(bits[62:52]) - 896;
        keep = bits[51:45];
        rest = bits[44:0];
        half = '0;
        half[44] = 1'b1;
        inex = (rest != 0) || (err != 0.0);
        if (rest > half) up = 1'b1;
        else if (rest < half) up = 1'b0;
        else if (err_mag > 0.0) up = 1'b1;
        else if (err_mag < 0.0) up = 1'b0;
        else up = keep[0];
        m = {2'b01, keep} + 9'(up);
        if (m[8]) begin
            e++;
            keep = '0;
        end else begin
            keep = m[6:0];
        end
        if (e >= 255) return {rs, 15'h7F80, 4'b0101};
        if (e <= 0) return {rs, 15'h0000, 4'b0011};
        return {rs, 8'(e), keep, 3'b000, inex};
    endfunction

    function automatic logic [15:0] rand_op(input logic [15:0] near);
        int k, e;
        logic s;
        logic [6:0] m;
        k = int'($urandom_range(0, 19));
        s = 1'($urandom);
        m = 7'($urandom);
        e = int'($urandom_range(1, 254));
        case (k)
            0: e = 0;
            1: begin e = 255; m = '0; end
            2: begin e = 255; m = m | 7'h01; end
            3, 4, 5: e = int'($urandom_range(1, 4));
            6, 7: e = int'($urandom_range(250, 254));
            8, 9, 10, 11, 12: begin
                e = int'(near[14:7]) + int'($urandom_range(0, 4)) - 2;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
            end
            13, 14: return {~near[15], near[14:2], 2'($urandom)};
            default: ;
        endcase
        return {s, 8'(e), m};
    endfunction

    function automatic logic ready_val();
        case (ready_mode)
            0: return 1'b1;
            1: return ($urandom_range(0, 3) != 0);
            default: return !(tcyc >= 4 && tcyc <= 7);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tcyc++;
            out_ready = ready_val();
            in_valid  = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [19:0] expv, input bit lat);
        int  waited = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            tcyc++;
            out_ready = ready_val();
            in_valid  = 1'b1;
            in_a      = a;
            in_b      = b;
            in_sub    = sub;
            #1;
            if (in_ready) begin
                sb_q.push_back('{res: expv[19:4], flags: expv[3:0], acc_cyc: cyc, lat: lat});
                done = 1;
            end else if (++waited > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
                done = 1;
            end
        end
    endtask

    task automatic send_rand(input bit lat);
        logic [15:0] a, b;
        logic        sub;
        a   = rand_op(16'h3F80);
        b   = rand_op(a);
        sub = 1'($urandom);
        send(a, b, sub, ref_model(a, b, sub), lat);
    endtask

    // Monitor: pops on transfer, checks hold-stability against the queue head while stalled.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got res=%h flags=%b, required no output", out_res, out_flags);
            end else begin
                e = sb_q[0];
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    chk("res", 32'(out_res), 32'(e.res));
                    chk("flags", 32'(out_flags), 32'(e.flags));
                    if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd3);
                end else begin
                    chk("stall_res", 32'(out_res), 32'(e.res));
                    chk("stall_flags", 32'(out_flags), 32'(e.flags));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res", 32'(out_res), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        ready_mode = 0;
        send(16'h3F80, 16'h4000, 1'b0, {16'h4040, 4'b0000}, 1'b1);
        idle(4);
        send(16'h3F80, 16'h3F80, 1'b1, {16'h0000, 4'b0000}, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, {16'h8000, 4'b0000}, 1'b0);
        send(16'h3F80, 16'h3B80, 1'b0, {16'h3F80, 4'b0001}, 1'b0);
        send(16'h3F81, 16'h3B80, 1'b0, {16'h3F82, 4'b0001}, 1'b0);
        send(16'h7F80, 16'hFF80, 1'b0, {16'h7FC0, 4'b1000}, 1'b0);
        send(16'h7F7F, 16'h7F7F, 1'b0, {16'h7F80, 4'b0101}, 1'b0);
        send(16'h7FC1, 16'h3F80, 1'b0, {16'h7FC0, 4'b0000}, 1'b0);
        send(16'h4049, 16'h0000, 1'b0, {16'h4049, 4'b0000}, 1'b0);
        send(16'h3F80, 16'h0080, 1'b0, {16'h3F80, 4'b0001}, 1'b0);
        send(16'h00C0, 16'h0080, 1'b1, {16'h0000, 4'b0011}, 1'b0);
        send(16'h0000, 16'h4000, 1'b1, {16'hC000, 4'b0000}, 1'b0);
        idle(5);

        // Back-to-back stream with out_ready low on cycles 4..7
        ready_mode = 2;
        tcyc = 0;
        for (int i = 0; i < 6; i++) begin
            send_rand(1'b0);
            if (tcyc >= 4 && tcyc <= 7) chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        while (tcyc < 8) begin
            idle(1);
            if (tcyc >= 4 && tcyc <= 7) chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        ready_mode = 0;
        idle(6);

        // Reset with three operations in flight
        send_rand(1'b0);
        send_rand(1'b0);
        send_rand(1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_res", 32'(out_res), 32'd0);
        chk("midrst_out_flags", 32'(out_flags), 32'd0);
        idle(2);
        send(16'h4000, 16'h3F80, 1'b1, {16'h3F80, 4'b0000}, 1'b1);
        idle(6);

        // Random traffic with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_rand(1'b0);
        end

        ready_mode = 0;
        begin
            int n = 0;
            while (sb_q.size() != 0 && n < 200) begin
                idle(1);
                n++;
            end
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
